chan_timer: RTL and testbench
=============================

CHAN_TIMER -- requirements
Module: chan_timer

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent countdown channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 4, width of each channel's count in ticks.
REQ-003 SHALL have parameter TICK_DIV, default 100_000_000, clock cycles per tick (1 s at 100 MHz); minimum 2.
REQ-004 SHALL have port clock  input  1  system clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  N_CH  per-channel load-and-run strobe.
REQ-007 SHALL have port value  input  N_CH*CNT_W  per-channel load value; channel i uses bits [i*CNT_W +: CNT_W].
REQ-008 SHALL have port abort  input  N_CH  per-channel cancel.
REQ-009 SHALL have port pause  input  N_CH  per-channel hold level.
REQ-010 SHALL have port periodic  input  N_CH  per-channel auto-reload mode select, sampled on start.
REQ-011 SHALL have port expired  output  N_CH  level, high when the channel count is 0.
REQ-012 SHALL have port expire_pulse  output  N_CH  one-cycle strobe on count reaching 0.
REQ-013 SHALL have port remaining  output  N_CH*CNT_W  current per-channel count.
REQ-014 SHALL have port one_hz_enable  output  1  one-cycle strobe every TICK_DIV cycles, free-running.
REQ-015 SHALL have port half_hz_enable  output  1  one-cycle strobe every 2*TICK_DIV cycles, coincident with every second one_hz_enable.

Function
REQ-016 Each channel SHALL be an FSM with states IDLE, RUN, PAUSED.
REQ-017 Per-cycle priority SHALL be abort > start > pause > tick.
REQ-018 abort SHALL force IDLE and count 0 next cycle, with no expire_pulse.
REQ-019 start with value>0 SHALL, next cycle, load count=value, clear the channel prescaler, latch periodic and value, and enter RUN; start in RUN or PAUSED restarts.
REQ-020 start with value=0 SHALL enter IDLE with count 0 and assert expire_pulse for one cycle.
REQ-021 In RUN, the channel prescaler SHALL count 0..TICK_DIV-1, and the count SHALL decrement in the cycle the prescaler wraps; expired rises exactly value*TICK_DIV cycles after the cycle following start.
REQ-022 pause high in RUN SHALL enter PAUSED, freezing the prescaler and count; pause low SHALL resume RUN with no phase loss.
REQ-023 On decrement 1->0, expire_pulse SHALL assert in the same cycle that count becomes 0; a one-shot channel then enters IDLE.
REQ-024 A periodic channel reaching 0 SHALL reload the latched value in the following cycle, remain in RUN, and keep expired high for exactly that one cycle.
REQ-025 expired[i] SHALL equal (count_i == 0); remaining SHALL equal the registered count.
REQ-026 The shared prescaler SHALL be free-running from reset and independent of channel activity.

Reset
REQ-027 Reset SHALL force all channels to IDLE, count 0, and prescalers 0; expired is all-ones; expire_pulse, one_hz_enable and half_hz_enable are 0; latched periodic is 0.
REQ-028 Reset asserted mid-count SHALL discard the countdown without asserting expire_pulse.

Configuration
REQ-029 With CHAN_TIMER_PERIODIC_EN defined, REQ-024 SHALL apply.
REQ-030 Without CHAN_TIMER_PERIODIC_EN, the periodic input SHALL be ignored, all channels are one-shot, and no reload logic is synthesized.

Structure
REQ-031 Package chan_timer_pkg SHALL hold the channel state enum and the default TICK_DIV constant.
REQ-032 Per-channel FSM, prescaler and count SHALL be sub-module chan_timer_ch, instantiated N_CH times by a generate loop.
REQ-033 The top level SHALL hold only the shared prescaler, half-rate toggle and port slicing.

Verification (TICK_DIV=4, CNT_W=4, N_CH=4)
REQ-034 Start ch0 with value=3 -> expired[0] low next cycle; remaining decrements every 4 cycles; expired[0] and expire_pulse[0] high 12 cycles later.
REQ-035 Start ch1 with value=2, pause for 5 cycles mid-count -> expiry delayed by exactly 5 cycles.
REQ-036 Start ch2 with value=2 and periodic=1 (macro on) -> expire_pulse every 9 cycles; abort -> IDLE with no pulse; macro off -> single pulse only.
REQ-037 In the same cycle on ch3: start with value=5 and abort -> IDLE; start with value=0 -> one expire_pulse, expired stays high.
REQ-038 Assert reset mid-count on all channels -> expired=4'hF, no pulses; one_hz_enable every 4 cycles and half_hz_enable every 8 cycles, aligned.

Source files
------------

// File: rtl/chan_timer_pkg.sv
// Shared types and constants for the multi-channel countdown timer.
package chan_timer_pkg;

    // Per-channel controller states.
    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_RUN    = 2'd1,
        CH_PAUSED = 2'd2
    } ch_state_e;

    // One tick per second at a 100 MHz system clock.
    localparam int unsigned TICK_DIV_DEFAULT = 100_000_000;

endpackage

// File: rtl/chan_timer_ch.sv
// One countdown channel: IDLE/RUN/PAUSED controller, tick prescaler and count.
// Auto-reload (periodic) mode exists only when CHAN_TIMER_PERIODIC_EN is defined.
module chan_timer_ch
    import chan_timer_pkg::*;
#(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             abort_i,
    input  logic             pause_i,
    input  logic             periodic_i,
    output logic             expired_o,
    output logic             expire_pulse_o,
    output logic [CNT_W-1:0] remaining_o
);

    localparam int unsigned     PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             pulse_q, pulse_d;

    logic             active_c;
    logic             advance_c;
    logic             wrap_c;
    logic             last_c;
    logic             reload_c;
    logic             stay_c;
    logic [CNT_W-1:0] reload_val_c;

    assign active_c  = (state_q != CH_IDLE);
    assign advance_c = active_c && !pause_i;
    assign wrap_c    = advance_c && (pre_q == PRE_MAX);
    assign last_c    = wrap_c && (cnt_q == CNT_W'(1));

`ifdef CHAN_TIMER_PERIODIC_EN
    logic             per_q, per_d;
    logic [CNT_W-1:0] val_q, val_d;

    // A periodic channel sits at zero for one cycle, then reloads.
    assign reload_c     = advance_c && per_q && (cnt_q == '0);
    assign stay_c       = per_q;
    assign reload_val_c = val_q;

    // Latched mode and reload value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            per_q <= 1'b0;
            val_q <= '0;
        end else begin
            per_q <= per_d;
            val_q <= val_d;
        end
    end

    // Capture mode and reload value on every start.
    always_comb begin
        per_d = per_q;
        val_d = val_q;
        if (!abort_i && start_i) begin
            per_d = periodic_i;
            val_d = value_i;
        end
    end
`else
    logic unused_periodic;

    assign unused_periodic = periodic_i;
    assign reload_c        = 1'b0;
    assign stay_c          = 1'b0;
    assign reload_val_c    = '0;
`endif

    // State, prescaler, count and pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            pulse_q <= pulse_d;
        end
    end

    // Next state: abort > start > pause > tick.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = CH_IDLE;
        end else if (start_i) begin
            state_d = (value_i != '0) ? CH_RUN : CH_IDLE;
        end else if (active_c) begin
            if (pause_i) begin
                state_d = CH_PAUSED;
            end else if (last_c && !stay_c) begin
                state_d = CH_IDLE;
            end else begin
                state_d = CH_RUN;
            end
        end
    end

    // Count, prescaler and expiry strobe updates with the same priority.
    always_comb begin
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        pulse_d = 1'b0;
        if (abort_i) begin
            cnt_d = '0;
            pre_d = '0;
        end else if (start_i) begin
            cnt_d   = value_i;
            pre_d   = '0;
            pulse_d = (value_i == '0);
        end else if (reload_c) begin
            cnt_d = reload_val_c;
            pre_d = '0;
        end else if (wrap_c) begin
            pre_d   = '0;
            cnt_d   = cnt_q - CNT_W'(1);
            pulse_d = (cnt_q == CNT_W'(1));
        end else if (advance_c) begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    assign expired_o      = (cnt_q == '0);
    assign expire_pulse_o = pulse_q;
    assign remaining_o    = cnt_q;

endmodule

// File: rtl/chan_timer.sv
// Multi-channel countdown timer: shared 1 Hz / 0.5 Hz strobes plus N_CH channels.
// Define CHAN_TIMER_PERIODIC_EN to enable per-channel auto-reload mode.
module chan_timer
    import chan_timer_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH*CNT_W-1:0] value,
    input  logic [N_CH-1:0]       abort,
    input  logic [N_CH-1:0]       pause,
    input  logic [N_CH-1:0]       periodic,
    output logic [N_CH-1:0]       expired,
    output logic [N_CH-1:0]       expire_pulse,
    output logic [N_CH*CNT_W-1:0] remaining,
    output logic                  one_hz_enable,
    output logic                  half_hz_enable
);

    localparam int unsigned      PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] sp_q;
    logic             one_q;
    logic             tog_q;
    logic             half_q;
    logic             sp_wrap_c;

    assign sp_wrap_c = (sp_q == PRE_MAX);

    // Free-running shared prescaler; half-rate strobe on every second wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp_q   <= '0;
            one_q  <= 1'b0;
            tog_q  <= 1'b0;
            half_q <= 1'b0;
        end else begin
            sp_q   <= sp_wrap_c ? '0 : sp_q + PRE_W'(1);
            one_q  <= sp_wrap_c;
            tog_q  <= tog_q ^ sp_wrap_c;
            half_q <= sp_wrap_c & tog_q;
        end
    end

    assign one_hz_enable  = one_q;
    assign half_hz_enable = half_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        chan_timer_ch #(
            .CNT_W    (CNT_W),
            .TICK_DIV (TICK_DIV)
        ) u_ch (
            .clock          (clock),
            .reset          (reset),
            .start_i        (start[i]),
            .value_i        (value[i*CNT_W +: CNT_W]),
            .abort_i        (abort[i]),
            .pause_i        (pause[i]),
            .periodic_i     (periodic[i]),
            .expired_o      (expired[i]),
            .expire_pulse_o (expire_pulse[i]),
            .remaining_o    (remaining[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_chan_timer.sv
// Self-checking bench for chan_timer (N_CH=4, CNT_W=4, TICK_DIV=4).
module tb_chan_timer;

    logic        clock;
    logic        reset;
    logic [3:0]  start;
    logic [15:0] value;
    logic [3:0]  abort;
    logic [3:0]  pause;
    logic [3:0]  periodic;
    logic [3:0]  expired;
    logic [3:0]  expire_pulse;
    logic [15:0] remaining;
    logic        one_hz_enable;
    logic        half_hz_enable;

`ifdef CHAN_TIMER_PERIODIC_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    typedef struct {
        int ch;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc    = 0;
    int  n_cmp  = 0;
    int  n_bad  = 0;

    chan_timer #(
        .N_CH     (4),
        .CNT_W    (4),
        .TICK_DIV (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .value          (value),
        .abort          (abort),
        .pause          (pause),
        .periodic       (periodic),
        .expired        (expired),
        .expire_pulse   (expire_pulse),
        .remaining      (remaining),
        .one_hz_enable  (one_hz_enable),
        .half_hz_enable (half_hz_enable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard monitor: every expiry strobe must match a queued expectation.
    always @(negedge clock) begin
        int hit;
        int j;
        if (reset) begin
            n_cmp++;
            if (expire_pulse !== 4'b0000) begin
                n_bad++;
                $display("FAIL pulse_in_reset: got %b expected 0000", expire_pulse);
            end
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                if (expire_pulse[ch] !== 1'b0) begin
                    hit = -1;
                    for (int e = 0; e < exp_q.size(); e++)
                        if (hit < 0 && exp_q[e].ch == ch && exp_q[e].cyc == cyc) hit = e;
                    n_cmp++;
                    if (hit < 0) begin
                        n_bad++;
                        $display("FAIL unexpected_pulse: ch%0d got %b at cycle %0d, none expected", ch, expire_pulse[ch], cyc);
                    end else begin
                        exp_q.delete(hit);
                    end
                end
            end
            j = 0;
            while (j < exp_q.size()) begin
                if (exp_q[j].cyc < cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missed_pulse: ch%0d got none, expected at cycle %0d", exp_q[j].ch, exp_q[j].cyc);
                    exp_q.delete(j);
                end else begin
                    j++;
                end
            end
        end
    end

    // Drop pending expectations of a channel that is restarted or cancelled.
    function automatic void flush_ch(input int ch);
        int j;
        j = 0;
        while (j < exp_q.size()) begin
            if (exp_q[j].ch == ch) exp_q.delete(j);
            else j++;
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = '0; value = '0; abort = '0; pause = '0; periodic = '0;
        repeat (3) @(negedge clock);
        n_cmp += 5;
        if (expired !== 4'hF) begin n_bad++; $display("FAIL rst_expired: got %h expected f", expired); end
        if (remaining !== 16'h0) begin n_bad++; $display("FAIL rst_remaining: got %h expected 0000", remaining); end
        if (expire_pulse !== 4'h0) begin n_bad++; $display("FAIL rst_pulse: got %h expected 0", expire_pulse); end
        if (one_hz_enable !== 1'b0) begin n_bad++; $display("FAIL rst_one_hz: got %b expected 0", one_hz_enable); end
        if (half_hz_enable !== 1'b0) begin n_bad++; $display("FAIL rst_half_hz: got %b expected 0", half_hz_enable); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_countdown();
        start[0] = 1'b1; value[3:0] = 4'd3;
        exp_q.push_back('{ch: 0, cyc: cyc + 1 + 12});
        @(negedge clock);
        start[0] = 1'b0;
        n_cmp += 2;
        if (expired[0] !== 1'b0) begin n_bad++; $display("FAIL cd_load_expired: got %b expected 0", expired[0]); end
        if (remaining[3:0] !== 4'd3) begin n_bad++; $display("FAIL cd_load_rem: got %0d expected 3", remaining[3:0]); end
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            n_cmp += 2;
            if (remaining[3:0] !== ((k >= 12) ? 4'd0 : 4'(3 - k / 4))) begin
                n_bad++; $display("FAIL cd_rem k=%0d: got %0d expected %0d", k, remaining[3:0], (k >= 12) ? 0 : 3 - k / 4);
            end
            if (expired[0] !== (k >= 12)) begin
                n_bad++; $display("FAIL cd_expired k=%0d: got %b expected %b", k, expired[0], k >= 12);
            end
        end
    endtask

    task automatic test_back_to_back();
        start[0] = 1'b1; value[3:0] = 4'd3;
        exp_q.push_back('{ch: 0, cyc: cyc + 1 + 12});
        @(negedge clock);
        start[0] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            start[0] = 1'b0;
            if (k == 5) begin
                start[0] = 1'b1; value[3:0] = 4'd2;
                flush_ch(0);
                exp_q.push_back('{ch: 0, cyc: cyc + 1 + 8});
            end
            if (k == 6 || k == 13 || k == 14) begin
                n_cmp++;
                if (expired[0] !== (k == 14) || (k == 6 && remaining[3:0] !== 4'd2)) begin
                    n_bad++; $display("FAIL restart k=%0d: got exp=%b rem=%0d expected exp=%b", k, expired[0], remaining[3:0], k == 14);
                end
            end
        end
    endtask

    task automatic test_pause();
        int eff;
        start[1] = 1'b1; value[7:4] = 4'd2;
        exp_q.push_back('{ch: 1, cyc: cyc + 1 + 8 + 5});
        @(negedge clock);
        start[1] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            eff = (k <= 3) ? k : ((k <= 8) ? 3 : k - 5);
            n_cmp += 2;
            if (remaining[7:4] !== 4'(2 - eff / 4)) begin
                n_bad++; $display("FAIL pause_rem k=%0d: got %0d expected %0d", k, remaining[7:4], 2 - eff / 4);
            end
            if (expired[1] !== (k >= 13)) begin
                n_bad++; $display("FAIL pause_expired k=%0d: got %b expected %b", k, expired[1], k >= 13);
            end
            pause[1] = (k >= 3 && k <= 7);
        end
        pause[1] = 1'b0;
    endtask

    task automatic test_periodic();
        start[2] = 1'b1; value[11:8] = 4'd2; periodic[2] = 1'b1;
        exp_q.push_back('{ch: 2, cyc: cyc + 1 + 8});
        if (PER_EN) begin
            exp_q.push_back('{ch: 2, cyc: cyc + 1 + 17});
            exp_q.push_back('{ch: 2, cyc: cyc + 1 + 26});
        end
        @(negedge clock);
        start[2] = 1'b0; periodic[2] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            abort[2] = (k == 28);
            if (k == 8) begin
                n_cmp++;
                if (expired[2] !== 1'b1) begin n_bad++; $display("FAIL per_zero: got %b expected 1", expired[2]); end
            end
            if (k == 9) begin
                n_cmp++;
                if (expired[2] !== !PER_EN || remaining[11:8] !== (PER_EN ? 4'd2 : 4'd0)) begin
                    n_bad++; $display("FAIL per_reload: got exp=%b rem=%0d expected exp=%b rem=%0d", expired[2], remaining[11:8], !PER_EN, PER_EN ? 2 : 0);
                end
            end
            if (k == 29 || k == 40) begin
                n_cmp++;
                if (expired[2] !== 1'b1 || remaining[11:8] !== 4'd0) begin
                    n_bad++; $display("FAIL per_abort k=%0d: got exp=%b rem=%0d expected exp=1 rem=0", k, expired[2], remaining[11:8]);
                end
            end
        end
        abort[2] = 1'b0;
    endtask

    task automatic test_same_cycle();
        start[3] = 1'b1; abort[3] = 1'b1; value[15:12] = 4'd5;
        @(negedge clock);
        start[3] = 1'b0; abort[3] = 1'b0;
        n_cmp++;
        if (expired[3] !== 1'b1 || remaining[15:12] !== 4'd0) begin
            n_bad++; $display("FAIL abort_wins: got exp=%b rem=%0d expected exp=1 rem=0", expired[3], remaining[15:12]);
        end
        repeat (6) @(negedge clock);
        n_cmp++;
        if (expired[3] !== 1'b1) begin n_bad++; $display("FAIL abort_idle: got %b expected 1", expired[3]); end
        start[3] = 1'b1; value[15:12] = 4'd0;
        exp_q.push_back('{ch: 3, cyc: cyc + 1});
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            start[3] = 1'b0;
            n_cmp++;
            if (expired[3] !== 1'b1 || remaining[15:12] !== 4'd0) begin
                n_bad++; $display("FAIL zero_start k=%0d: got exp=%b rem=%0d expected exp=1 rem=0", k, expired[3], remaining[15:12]);
            end
        end
    endtask

    task automatic test_reset_midcount();
        start = 4'hF; value = 16'h9999; periodic = 4'hF;
        @(negedge clock);
        start = '0; periodic = '0;
        repeat (6) @(negedge clock);
        n_cmp++;
        if (expired !== 4'h0) begin n_bad++; $display("FAIL mid_running: got %h expected 0", expired); end
        reset = 1'b1;
        #1;
        n_cmp += 3;
        if (expired !== 4'hF) begin n_bad++; $display("FAIL mid_rst_expired: got %h expected f", expired); end
        if (remaining !== 16'h0) begin n_bad++; $display("FAIL mid_rst_rem: got %h expected 0000", remaining); end
        if (one_hz_enable !== 1'b0 || half_hz_enable !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_strobes: got %b%b expected 00", one_hz_enable, half_hz_enable);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            n_cmp += 3;
            if (one_hz_enable !== (k % 4 == 0)) begin
                n_bad++; $display("FAIL one_hz k=%0d: got %b expected %b", k, one_hz_enable, k % 4 == 0);
            end
            if (half_hz_enable !== (k % 8 == 0)) begin
                n_bad++; $display("FAIL half_hz k=%0d: got %b expected %b", k, half_hz_enable, k % 8 == 0);
            end
            if (expired !== 4'hF) begin
                n_bad++; $display("FAIL post_rst_expired k=%0d: got %h expected f", k, expired);
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_back_to_back();
        test_pause();
        test_periodic();
        test_same_cycle();
        test_reset_midcount();
        repeat (2) @(negedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL pending_pulses: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
